// File: rtl/dmem_ctrl.sv
// dmem_ctrl: MEM-stage data-memory responder for the RV32I pipeline.
// Drives a single-port synchronous SRAM with WAIT_STATES extra cycles,
// stalls the pipeline until completion and returns aligned, extended load data.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN -- when defined, misaligned
// half/word requests skip the SRAM and complete next cycle with misalign=1;
// when undefined, misaligned low address bits are ignored and misalign is 0.
module dmem_ctrl #(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_en,
  input  logic                  req_wr,
  input  logic [3:0]            req_byte,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  stall,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  misalign,
  output logic                  sram_ce,
  output logic                  sram_we,
  output logic [3:0]            sram_be,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [31:0]           sram_wdata,
  input  logic [31:0]           sram_rdata
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_INIT =
    (WAIT_STATES == 0) ? '0 : CNT_W'(WAIT_STATES - 32'd1);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_e;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  size_e                   size_q, size_d;
  logic [1:0]              off_q, off_d;
  logic                    wr_q, wr_d;
  logic                    uns_q, uns_d;
  logic                    misal_q, misal_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    misalign_q, misalign_d;
  logic                    sram_ce_q, sram_ce_d;
  logic                    sram_we_q, sram_we_d;
  logic [3:0]              sram_be_q, sram_be_d;
  logic [ADDR_WIDTH-1:0]   sram_addr_q, sram_addr_d;
  logic [31:0]             sram_wdata_q, sram_wdata_d;

  size_e       req_size_c;
  logic [1:0]  req_off_c;
  logic [3:0]  req_be_c;
  logic [31:0] req_wdata_sh_c;
  logic        req_misal_c;
  logic [31:0] ld_shift_c;
  logic [31:0] ld_data_c;

  // Upper byte-address bits beyond the SRAM depth are intentionally dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH+2];

  // Decode the incoming request: size, effective lane offset, lane mask, shifted data.
  always_comb begin
    req_size_c = SZ_WORD;
    req_off_c  = 2'd0;
    req_be_c   = 4'b1111;
    case (req_byte)
      4'b0001: begin
        req_size_c = SZ_BYTE;
        req_off_c  = req_addr[1:0];
        req_be_c   = 4'b0001 << req_off_c;
      end
      4'b0011: begin
        req_size_c = SZ_HALF;
        req_off_c  = {req_addr[1], 1'b0};
        req_be_c   = 4'b0011 << req_off_c;
      end
      default: ;
    endcase
    req_wdata_sh_c = req_wdata << {req_off_c, 3'b000};
`ifdef DMEM_MISALIGN_TRAP_EN
    req_misal_c = ((req_size_c == SZ_HALF) && req_addr[0]) ||
                  ((req_size_c == SZ_WORD) && (req_addr[1:0] != 2'd0));
`else
    req_misal_c = 1'b0;
`endif
  end

  // Align SRAM read data to bit 0 and extend to 32 bits.
  always_comb begin
    ld_shift_c = sram_rdata >> {off_q, 3'b000};
    case (size_q)
      SZ_BYTE: ld_data_c = {{24{ld_shift_c[7] & ~uns_q}}, ld_shift_c[7:0]};
      SZ_HALF: ld_data_c = {{16{ld_shift_c[15] & ~uns_q}}, ld_shift_c[15:0]};
      default: ld_data_c = ld_shift_c;
    endcase
  end

  // Response data: live in DONE, held afterwards until the next completion.
  always_comb begin
    rsp_rdata = rdata_q;
    if (state_q == DONE) begin
      rsp_rdata = (wr_q || misal_q) ? 32'd0 : ld_data_c;
    end
  end

  // Pipeline hold: from request acceptance until the completing cycle.
  assign stall = ~rst & (((state_q == IDLE) & req_en) |
                         (state_q == ACCESS) | (state_q == WAIT));

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    size_d       = size_q;
    off_d        = off_q;
    wr_d         = wr_q;
    uns_d        = uns_q;
    misal_d      = misal_q;
    rdata_d      = rdata_q;
    rsp_valid_d  = 1'b0;
    misalign_d   = 1'b0;
    sram_ce_d    = 1'b0;
    sram_we_d    = 1'b0;
    sram_be_d    = sram_be_q;
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    case (state_q)
      IDLE: begin
        if (req_en) begin
          size_d  = req_size_c;
          off_d   = req_off_c;
          wr_d    = req_wr;
          uns_d   = req_unsigned;
          misal_d = req_misal_c;
          if (req_misal_c) begin
            state_d     = DONE;
            rsp_valid_d = 1'b1;
            misalign_d  = 1'b1;
          end else begin
            state_d      = ACCESS;
            sram_ce_d    = 1'b1;
            sram_we_d    = req_wr;
            sram_be_d    = req_be_c;
            sram_addr_d  = req_addr[ADDR_WIDTH+1:2];
            sram_wdata_d = req_wdata_sh_c;
          end
        end
      end
      ACCESS: begin
        if (WAIT_STATES == 0) begin
          state_d     = DONE;
          rsp_valid_d = 1'b1;
        end else begin
          cnt_d   = CNT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d     = DONE;
          rsp_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        rdata_d = rsp_rdata;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      size_q       <= SZ_WORD;
      off_q        <= '0;
      wr_q         <= 1'b0;
      uns_q        <= 1'b0;
      misal_q      <= 1'b0;
      rdata_q      <= '0;
      rsp_valid_q  <= 1'b0;
      misalign_q   <= 1'b0;
      sram_ce_q    <= 1'b0;
      sram_we_q    <= 1'b0;
      sram_be_q    <= '0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      size_q       <= size_d;
      off_q        <= off_d;
      wr_q         <= wr_d;
      uns_q        <= uns_d;
      misal_q      <= misal_d;
      rdata_q      <= rdata_d;
      rsp_valid_q  <= rsp_valid_d;
      misalign_q   <= misalign_d;
      sram_ce_q    <= sram_ce_d;
      sram_we_q    <= sram_we_d;
      sram_be_q    <= sram_be_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign misalign   = misalign_q;
  assign sram_ce    = sram_ce_q;
  assign sram_we    = sram_we_q;
  assign sram_be    = sram_be_q;
  assign sram_addr  = sram_addr_q;
  assign sram_wdata = sram_wdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: three controllers (WAIT_STATES 1, 0, 3), each with its own SRAM model.
module tb_dmem_ctrl;

  localparam int unsigned AW = 12;
  localparam int NI = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [NI-1:0]          rst;
  logic [NI-1:0]          req_en, req_wr, req_uns;
  logic [NI-1:0][3:0]     req_byte;
  logic [NI-1:0][31:0]    req_addr, req_wdata;
  logic [NI-1:0]          stall, rsp_valid, misalign, sram_ce, sram_we;
  logic [NI-1:0][31:0]    rsp_rdata, sram_wdata;
  logic [NI-1:0][3:0]     sram_be;
  logic [NI-1:0][AW-1:0]  sram_addr;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned WS = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
    logic [31:0] mem [2**AW];
    logic [31:0] rd;

    dmem_ctrl #(.ADDR_WIDTH(AW), .WAIT_STATES(WS)) u_dut (
      .clk(clk), .rst(rst[g]),
      .req_en(req_en[g]), .req_wr(req_wr[g]), .req_byte(req_byte[g]),
      .req_unsigned(req_uns[g]), .req_addr(req_addr[g]), .req_wdata(req_wdata[g]),
      .stall(stall[g]), .rsp_valid(rsp_valid[g]), .rsp_rdata(rsp_rdata[g]),
      .misalign(misalign[g]), .sram_ce(sram_ce[g]), .sram_we(sram_we[g]),
      .sram_be(sram_be[g]), .sram_addr(sram_addr[g]), .sram_wdata(sram_wdata[g]),
      .sram_rdata(rd)
    );

    initial begin
      for (int j = 0; j < 2**AW; j++) mem[j] = 32'd0;
    end

    // Synchronous SRAM: read data registered and held until the next read.
    always @(posedge clk) begin
      if (rst[g]) rd <= 32'd0;
      else if (sram_ce[g]) begin
        if (sram_we[g]) begin
          for (int b = 0; b < 4; b++)
            if (sram_be[g][b]) mem[sram_addr[g]][8*b +: 8] = sram_wdata[g][8*b +: 8];
        end else begin
          rd <= mem[sram_addr[g]];
        end
      end
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
  endtask

  // Byte-addressed reference memory for instance 0.
  logic [7:0] rmem [2**(AW+2)];

  function automatic void ref_exp(input logic wr, input logic [3:0] bm, input logic u,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  output logic [31:0] rd, output logic mis,
                                  output logic [3:0] be);
    int n, ba, lane;
    logic [31:0] v;
    n    = (bm == 4'b0001) ? 1 : ((bm == 4'b0011) ? 2 : 4);
    ba   = int'(a[AW+1:0]);
    ba   = ba - (ba % n);
    lane = ba % 4;
    be   = 4'(((1 << n) - 1) << lane);
    mis  = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    mis = (int'(a[1:0]) % n) != 0;
`endif
    rd = 32'd0;
    if (mis) return;
    if (wr) begin
      for (int j = 0; j < n; j++) rmem[ba+j] = wd[8*j +: 8];
    end else begin
      v = 32'd0;
      for (int j = 0; j < n; j++) v[8*j +: 8] = rmem[ba+j];
      if (!u && v[8*n-1]) for (int j = n; j < 4; j++) v[8*j +: 8] = 8'hFF;
      rd = v;
    end
  endfunction

  typedef struct {
    int          lat;
    int          stall_n;
    int          ce_n;
    logic [31:0] rd;
    logic        mis;
    logic        we1;
    logic [3:0]  be1;
    logic [AW-1:0] addr1;
    logic [31:0] wd1;
  } res_t;

  // One request: hold req_en until the completing cycle, then verify no re-accept.
  task automatic run_req(input int i, input logic wr, input logic [3:0] bm, input logic u,
                         input logic [31:0] a, input logic [31:0] wd, output res_t r);
    r.lat = -1; r.stall_n = 0; r.ce_n = 0; r.rd = '0; r.mis = 1'b0;
    r.we1 = 1'b0; r.be1 = '0; r.addr1 = '0; r.wd1 = '0;
    @(negedge clk);
    req_wr[i] = wr; req_byte[i] = bm; req_uns[i] = u;
    req_addr[i] = a; req_wdata[i] = wd; req_en[i] = 1'b1;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (stall[i]) r.stall_n++;
      if (sram_ce[i]) r.ce_n++;
      if (k == 1) begin
        r.we1 = sram_we[i]; r.be1 = sram_be[i];
        r.addr1 = sram_addr[i]; r.wd1 = sram_wdata[i];
      end
      if (rsp_valid[i]) begin
        r.lat = k; r.rd = rsp_rdata[i]; r.mis = misalign[i];
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    req_en[i] = 1'b0;
    #1;
    chk("no_reaccept_after_done", {30'd0, sram_ce[i], stall[i]}, 32'd0);
  endtask

  // Check one instance-0 result against the reference model.
  task automatic check_ref(input string tag, input res_t r, input logic wr, input logic [3:0] bm,
                           input logic u, input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] erd;
    logic emis;
    logic [3:0] ebe;
    ref_exp(wr, bm, u, a, wd, erd, emis, ebe);
    chk({tag, "_rdata"}, r.rd, erd);
    chk({tag, "_misalign"}, 32'(r.mis), 32'(emis));
    chk({tag, "_latency"}, r.lat, emis ? 1 : 3);
    chk({tag, "_stall_cycles"}, r.stall_n, emis ? 1 : 3);
    chk({tag, "_ce_cycles"}, r.ce_n, emis ? 0 : 1);
    if (!emis) chk({tag, "_be"}, 32'(r.be1), 32'(ebe));
  endtask

  typedef struct {
    logic        wr;
    logic [3:0]  bm;
    logic        u;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic [3:0]  exp_be;
    logic [AW-1:0] exp_saddr;
    logic [31:0] exp_swd;
  } vec_t;

  vec_t vecs [16];

  initial begin : main
    res_t r;
    logic [31:0] drd;
    logic dmis;
    logic [3:0] dbe;
    int vcnt;

    vecs[0]  = '{1'b1, 4'b1111, 1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0000, 4'b1111, 12'h040, 32'hDEAD_BEEF};
    vecs[1]  = '{1'b0, 4'b1111, 1'b0, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 4'b1111, 12'h040, 32'h0};
    vecs[2]  = '{1'b1, 4'b0001, 1'b0, 32'h0000_0103, 32'h0000_00A5, 32'h0000_0000, 4'b1000, 12'h040, 32'hA500_0000};
    vecs[3]  = '{1'b0, 4'b0001, 1'b0, 32'h0000_0103, 32'h0,         32'hFFFF_FFA5, 4'b1000, 12'h040, 32'h0};
    vecs[4]  = '{1'b0, 4'b0001, 1'b1, 32'h0000_0103, 32'h0,         32'h0000_00A5, 4'b1000, 12'h040, 32'h0};
    vecs[5]  = '{1'b1, 4'b0011, 1'b0, 32'h0000_0102, 32'h0000_8001, 32'h0000_0000, 4'b1100, 12'h040, 32'h8001_0000};
    vecs[6]  = '{1'b0, 4'b0011, 1'b0, 32'h0000_0102, 32'h0,         32'hFFFF_8001, 4'b1100, 12'h040, 32'h0};
    vecs[7]  = '{1'b0, 4'b0011, 1'b1, 32'h0000_0102, 32'h0,         32'h0000_8001, 4'b1100, 12'h040, 32'h0};
    vecs[8]  = '{1'b0, 4'b1111, 1'b0, 32'h0000_0100, 32'h0,         32'h8001_BEEF, 4'b1111, 12'h040, 32'h0};
    vecs[9]  = '{1'b0, 4'b0001, 1'b0, 32'h0000_0100, 32'h0,         32'hFFFF_FFEF, 4'b0001, 12'h040, 32'h0};
    vecs[10] = '{1'b0, 4'b0001, 1'b1, 32'h0000_0101, 32'h0,         32'h0000_00BE, 4'b0010, 12'h040, 32'h0};
    vecs[11] = '{1'b0, 4'b0011, 1'b0, 32'h0000_0100, 32'h0,         32'hFFFF_BEEF, 4'b0011, 12'h040, 32'h0};
    vecs[12] = '{1'b0, 4'b0101, 1'b0, 32'h0000_0100, 32'h0,         32'h8001_BEEF, 4'b1111, 12'h040, 32'h0};
    vecs[13] = '{1'b0, 4'b0011, 1'b0, 32'h0000_007E, 32'h0,         32'h0000_0000, 4'b1100, 12'h01F, 32'h0};
    vecs[14] = '{1'b1, 4'b1111, 1'b0, 32'hFFFF_3FFC, 32'h1357_9BDF, 32'h0000_0000, 4'b1111, 12'hFFF, 32'h1357_9BDF};
    vecs[15] = '{1'b0, 4'b0001, 1'b0, 32'h0000_3FFC, 32'h0,         32'hFFFF_FFDF, 4'b0001, 12'hFFF, 32'h0};

    for (int j = 0; j < 2**(AW+2); j++) rmem[j] = 8'h00;
    rst = '1; req_en = '0; req_wr = '0; req_uns = '0;
    req_byte = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    for (int i = 0; i < NI; i++) begin
      chk("reset_ctl", {27'd0, stall[i], rsp_valid[i], misalign[i], sram_ce[i], sram_we[i]}, 32'd0);
      chk("reset_rdata", rsp_rdata[i], 32'd0);
      chk("reset_sram", {16'd0, sram_be[i], sram_addr[i]} | sram_wdata[i], 32'd0);
    end
    rst = '0;

    // Directed table on WAIT_STATES=1.
    for (int v = 0; v < 16; v++) begin
      run_req(0, vecs[v].wr, vecs[v].bm, vecs[v].u, vecs[v].addr, vecs[v].wd, r);
      ref_exp(vecs[v].wr, vecs[v].bm, vecs[v].u, vecs[v].addr, vecs[v].wd, drd, dmis, dbe);
      chk($sformatf("vec%0d_rdata", v), r.rd, vecs[v].exp_rd);
      chk($sformatf("vec%0d_be", v), 32'(r.be1), 32'(vecs[v].exp_be));
      chk($sformatf("vec%0d_sram_addr", v), 32'(r.addr1), 32'(vecs[v].exp_saddr));
      chk($sformatf("vec%0d_sram_wdata", v), r.wd1, vecs[v].exp_swd);
      chk($sformatf("vec%0d_sram_we", v), 32'(r.we1), 32'(vecs[v].wr));
      chk($sformatf("vec%0d_latency", v), r.lat, 3);
      chk($sformatf("vec%0d_stall_cycles", v), r.stall_n, 3);
      chk($sformatf("vec%0d_misalign", v), 32'(r.mis), 32'd0);
    end

    // Misaligned half/word requests: trapped or silently aligned depending on the build.
    run_req(0, 1'b0, 4'b1111, 1'b0, 32'h0000_0101, 32'h0, r);
    check_ref("mis_lw101", r, 1'b0, 4'b1111, 1'b0, 32'h0000_0101, 32'h0);
    run_req(0, 1'b0, 4'b0011, 1'b1, 32'h0000_0103, 32'h0, r);
    check_ref("mis_lhu103", r, 1'b0, 4'b0011, 1'b1, 32'h0000_0103, 32'h0);
    run_req(0, 1'b1, 4'b1111, 1'b0, 32'h0000_0102, 32'hCAFE_F00D, r);
    check_ref("mis_sw102", r, 1'b1, 4'b1111, 1'b0, 32'h0000_0102, 32'hCAFE_F00D);
    run_req(0, 1'b0, 4'b1111, 1'b0, 32'h0000_0100, 32'h0, r);
    check_ref("mis_lw100_after", r, 1'b0, 4'b1111, 1'b0, 32'h0000_0100, 32'h0);

    // Wait-state timing: WAIT_STATES=0 (inst 1) and 3 (inst 2).
    run_req(1, 1'b1, 4'b1111, 1'b0, 32'h0000_0204, 32'h1234_5678, r);
    chk("ws0_sw_latency", r.lat, 2);
    run_req(1, 1'b0, 4'b1111, 1'b0, 32'h0000_0204, 32'h0, r);
    chk("ws0_lw_latency", r.lat, 2);
    chk("ws0_lw_stall_cycles", r.stall_n, 2);
    chk("ws0_lw_rdata", r.rd, 32'h1234_5678);
    run_req(2, 1'b1, 4'b1111, 1'b0, 32'h0000_0204, 32'h8765_4321, r);
    chk("ws3_sw_latency", r.lat, 5);
    run_req(2, 1'b0, 4'b1111, 1'b0, 32'h0000_0204, 32'h0, r);
    chk("ws3_lw_latency", r.lat, 5);
    chk("ws3_lw_stall_cycles", r.stall_n, 5);
    chk("ws3_lw_rdata", r.rd, 32'h8765_4321);
    run_req(2, 1'b0, 4'b0011, 1'b0, 32'h0000_0206, 32'h0, r);
    chk("ws3_lh_rdata", r.rd, 32'hFFFF_8765);

    // Reset in WAIT on WAIT_STATES=3: everything clears, no response follows.
    @(negedge clk);
    req_wr[2] = 1'b0; req_byte[2] = 4'b1111; req_uns[2] = 1'b0;
    req_addr[2] = 32'h0000_0208; req_wdata[2] = 32'h0; req_en[2] = 1'b1;
    @(negedge clk);
    @(negedge clk); #1;
    chk("rst_mid_pre_stall", 32'(stall[2]), 32'd1);
    rst[2] = 1'b1; req_en[2] = 1'b0;
    @(negedge clk); #1;
    chk("rst_mid_ctl", {27'd0, stall[2], rsp_valid[2], misalign[2], sram_ce[2], sram_we[2]}, 32'd0);
    chk("rst_mid_rdata", rsp_rdata[2], 32'd0);
    chk("rst_mid_sram", {16'd0, sram_be[2], sram_addr[2]} | sram_wdata[2], 32'd0);
    rst[2] = 1'b0;
    vcnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); #1;
      if (rsp_valid[2] || stall[2]) vcnt++;
    end
    chk("rst_mid_no_rsp", vcnt, 0);

    // Randomized traffic on WAIT_STATES=1 against the reference model.
    for (int t = 0; t < 150; t++) begin
      logic wr, u;
      logic [3:0] bm;
      logic [31:0] a, wd;
      wr = 1'($urandom_range(0, 1));
      u  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: bm = 4'b0001;
        1: bm = 4'b0011;
        2: bm = 4'b1111;
        default: bm = 4'($urandom());
      endcase
      a  = ($urandom() & 32'hFFFF_C000) | 32'($urandom_range(0, 31));
      wd = $urandom();
      run_req(0, wr, bm, u, a, wd, r);
      check_ref($sformatf("rand%0d", t), r, wr, bm, u, a, wd);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks so far", n_pass, n_chk);
    $fatal(1);
  end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

- Data-memory responder for the pipelined RV32I core; sits in the MEM stage.
- Accepts the MEM-stage request signals produced by pipeline control: enable, write, unshifted byte-size mask, address, write data.
- Drives a single-port synchronous SRAM with configurable wait states and stalls the pipeline until the access completes.
- Returns load data aligned, sign-extended or zero-extended, ready for writeback.

## Interface
Parameters:
- ADDR_WIDTH, 12, SRAM word-address width; SRAM depth is 2^ADDR_WIDTH words.
- WAIT_STATES, 1, extra SRAM cycles beyond one; legal range 0..15.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_en  in  1  MEM-stage memory request.
- req_wr  in  1  1 = store, 0 = load.
- req_byte  in  4  size mask, unshifted: 0001 byte, 0011 half, 1111 word; any other value is treated as 1111.
- req_unsigned  in  1  funct3[2]; 1 = LBU/LHU zero-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- stall  out  1  hold the MEM stage and all upstream stages.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  aligned, extended load data; 0 for stores.
- misalign  out  1  misaligned-request pulse; tied 0 unless the macro is set.
- sram_ce, sram_we  out  1  SRAM chip enable and write enable.
- sram_be  out  4  SRAM lane enables.
- sram_addr  out  ADDR_WIDTH  SRAM word address, req_addr[ADDR_WIDTH+1:2].
- sram_wdata  out  32  lane-shifted store data.
- sram_rdata  in  32  SRAM read data.

## Operation
- FSM states: IDLE, ACCESS, WAIT, DONE.
- IDLE:
  - With req_en=1: latch the request, compute the lane offset off=req_addr[1:0], and go to ACCESS.
  - Lane mask: sram_be = mask << off. A half uses off[1] only; a word uses off=0.
  - Store data: sram_wdata = req_wdata << 8*off.
- ACCESS: sram_ce=1 and sram_we=req_wr for exactly one cycle.
  - WAIT_STATES=0: go to DONE.
  - Otherwise: load the wait counter with WAIT_STATES-1 and go to WAIT.
- WAIT: decrement the counter; go to DONE when it reaches 0.
- DONE:
  - Load: sample sram_rdata, shift right by 8*off, mask to the access size, then sign-extend, or zero-extend when req_unsigned=1.
  - Register rsp_rdata, pulse rsp_valid, go to IDLE.
  - req_en in DONE is ignored; it still belongs to the completing instruction.
- stall is combinational:
  - 1 in IDLE when req_en=1.
  - 1 throughout ACCESS and WAIT.
  - 0 in DONE and in IDLE without a request.
- Store to SRAM: only lanes with sram_be set are written; the SRAM itself is outside this block.
- Reset mid-operation: state goes to IDLE and all outputs clear. An SRAM write already issued may still complete; no response is produced.
- Reset values: stall=0, rsp_valid=0, rsp_rdata=0, misalign=0, sram_ce=0, sram_we=0, sram_be=0, sram_addr=0, sram_wdata=0.

## Timing
- Request seen in IDLE at cycle T.
- sram_* outputs are registered and valid at T+1 (ACCESS).
- SRAM data must be valid WAIT_STATES+1 cycles after sram_ce, i.e. at T+2+WAIT_STATES.
- DONE occurs at T+2+WAIT_STATES; rsp_valid and rsp_rdata are valid in that cycle, and stall=0 in that cycle.
- stall is high for exactly WAIT_STATES+2 cycles, T through T+1+WAIT_STATES.
- Loads and stores take identical time.
- Back-to-back requests: the next instruction's req_en is sampled no earlier than T+3+WAIT_STATES. Peak rate is one access per WAIT_STATES+3 cycles.
- rsp_rdata holds its value until the next DONE.

## Configuration
- DMEM_MISALIGN_TRAP_EN defined:
  - Misaligned means a half with off[0]=1, or a word with off≠0.
  - A misaligned request skips ACCESS and WAIT; sram_ce stays 0.
  - Next cycle: DONE with rsp_valid=1, misalign=1, rsp_rdata=0; stall is high for 1 cycle only.
- DMEM_MISALIGN_TRAP_EN undefined:
  - misalign is tied 0.
  - Misaligned low address bits are silently ignored: a half uses off[1] only, a word uses off=0.
  - The access proceeds normally.

## Test plan
- WAIT_STATES=1; store word 0xDEADBEEF to 0x100, then LW 0x100:
  - sram_addr=0x040, be=1111 at T+1.
  - rsp_rdata=0xDEADBEEF at T+3.
  - stall high for 3 cycles.
- SB 0x000000A5 to 0x103: be=1000, sram_wdata=0xA5000000. Then LB 0x103 -> 0xFFFFFFA5; LBU 0x103 -> 0x000000A5.
- SH 0x00008001 to 0x102: be=1100. LH 0x102 -> 0xFFFF8001; LHU -> 0x00008001.
- WAIT_STATES=0 versus 3, LW:
  - rsp_valid at T+2 versus T+5.
  - stall length 2 versus 5.
  - No second access starts while req_en is held through DONE.
- rst asserted during WAIT: next cycle state is IDLE and all outputs are 0; no rsp_valid pulse follows.
- DMEM_MISALIGN_TRAP_EN defined, LW 0x101:
  - sram_ce never asserts.
  - rsp_valid=1, misalign=1, rsp_rdata=0 at T+1.
- Same request with the macro undefined: reads word 0x100 normally.
